// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch issue stage: instruction field layout,
// opcode constants and the decoded-instruction / issue-slot types.
package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  localparam logic [3:0] OP_NOP = 4'h0;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 9;
  localparam int SA_MSB  = 8;
  localparam int SA_LSB  = 6;
  localparam int SB_MSB  = 5;
  localparam int SB_LSB  = 3;
  localparam int SC_MSB  = 2;
  localparam int SC_LSB  = 0;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic [REG_AW-1:0] src_c;
  } instr_t;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_c;
  } slot_t;

  function automatic instr_t decode(input logic [DATA_W-1:0] word);
    instr_t d;
    d.opcode = word[OP_MSB:OP_LSB];
    d.dest   = word[DST_MSB:DST_LSB];
    d.src_a  = word[SA_MSB:SA_LSB];
    d.src_b  = word[SB_MSB:SB_LSB];
    d.src_c  = word[SC_MSB:SC_LSB];
    return d;
  endfunction

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// RAW/WAW scoreboard: one busy flop per architectural register, set on issue and
// cleared on writeback, with four combinational lookups.
module operand_fetch_reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic [REG_AW-1:0] rd_a_idx_i,
  input  logic [REG_AW-1:0] rd_b_idx_i,
  input  logic [REG_AW-1:0] rd_c_idx_i,
  input  logic [REG_AW-1:0] rd_d_idx_i,
  output logic              busy_a_o,
  output logic              busy_b_o,
  output logic              busy_c_o,
  output logic              busy_d_o,
  output logic [NREG-1:0]   busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Set is OR-ed in after the clear, so a new issue to a register that is
  // retiring in the same cycle stays marked busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask[set_idx_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_a_o   = busy_q[rd_a_idx_i];
  assign busy_b_o   = busy_q[rd_b_idx_i];
  assign busy_c_o   = busy_q[rd_c_idx_i];
  assign busy_d_o   = busy_q[rd_d_idx_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage in front of the 8x16 register file: decodes source fields, stalls on
// pending writebacks and captures opcode/dest/operands into a single output slot.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  output logic [REG_AW-1:0] SrcA,
  output logic [REG_AW-1:0] SrcB,
  output logic [REG_AW-1:0] SrcC,
  input  logic [DATA_W-1:0] OutBusA,
  input  logic [DATA_W-1:0] OutBusB,
  input  logic [DATA_W-1:0] OutBusC,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_opA,
  output logic [DATA_W-1:0] out_opB,
  output logic [DATA_W-1:0] out_opC,
  output logic [NREG-1:0]   busy_vec
);

  instr_t dec;
  logic   is_nop;
  logic   busy_a, busy_b, busy_c, busy_d;
  logic   hazard;
  logic   slot_free;
  logic   fire;

  slot_t  slot_q, slot_d;
  logic   valid_q, valid_d;

  assign dec    = decode(in_instr);
  assign is_nop = (dec.opcode == OP_NOP);

  assign SrcA = dec.src_a;
  assign SrcB = dec.src_b;
  assign SrcC = dec.src_c;

  operand_fetch_reg_scoreboard u_sb (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .set_en_i   (fire & ~is_nop),
    .set_idx_i  (dec.dest),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_dest),
    .rd_a_idx_i (dec.src_a),
    .rd_b_idx_i (dec.src_b),
    .rd_c_idx_i (dec.src_c),
    .rd_d_idx_i (dec.dest),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b),
    .busy_c_o   (busy_c),
    .busy_d_o   (busy_d),
    .busy_vec_o (busy_vec)
  );

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready never looks at in_valid except via the hazard term; the output
  // slot holds its contents stable while out_valid=1 and out_ready=0.
  assign hazard    = in_valid & ~is_nop & (busy_a | busy_b | busy_c | busy_d);
  assign slot_free = ~valid_q | out_ready;
  assign in_ready  = slot_free & ~hazard;
  assign fire      = in_valid & in_ready;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (fire) begin
      slot_d.opcode = dec.opcode;
      slot_d.dest   = dec.dest;
      slot_d.op_a   = OutBusA;
      slot_d.op_b   = OutBusB;
      slot_d.op_c   = OutBusC;
      valid_d       = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_opcode = slot_q.opcode;
  assign out_dest   = slot_q.dest;
  assign out_opA    = slot_q.op_a;
  assign out_opB    = slot_q.op_b;
  assign out_opC    = slot_q.op_c;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: regfile model Rk = k*16'h0101, expected issue
// slots queued at acceptance and compared when execute consumes them.
module tb_operand_fetch;

  logic        Clk;
  logic        Rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic [2:0]  SrcA, SrcB, SrcC;
  logic [15:0] OutBusA, OutBusB, OutBusC;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_dest;
  logic [15:0] out_opA, out_opB, out_opC;
  logic [7:0]  busy_vec;

  logic [54:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  operand_fetch dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .SrcC       (SrcC),
    .OutBusA    (OutBusA),
    .OutBusB    (OutBusB),
    .OutBusC    (OutBusC),
    .wb_valid   (wb_valid),
    .wb_dest    (wb_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_dest   (out_dest),
    .out_opA    (out_opA),
    .out_opB    (out_opB),
    .out_opC    (out_opC),
    .busy_vec   (busy_vec)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] rv(input logic [2:0] k);
    return {5'd0, k, 5'd0, k};
  endfunction

  assign OutBusA = rv(SrcA);
  assign OutBusB = rv(SrcB);
  assign OutBusC = rv(SrcC);

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c);
    return {op, d, a, b, c};
  endfunction

  function automatic logic [54:0] exp_of(input logic [15:0] w);
    logic [2:0] fa, fb, fc;
    fa = w[8:6];
    fb = w[5:3];
    fc = w[2:0];
    return {w[15:12], w[11:9], rv(fa), rv(fb), rv(fc)};
  endfunction

  function automatic logic [54:0] obs_slot();
    return {out_opcode, out_dest, out_opA, out_opB, out_opC};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: settle = sample at falling edge and run the output monitor
  task automatic settle();
    logic [54:0] e;
    @(negedge Clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_out: observed slot %0h expected none", obs_slot());
      end else begin
        e = exp_q.pop_front();
        chk("out_slot", {9'd0, obs_slot()}, {9'd0, e});
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    step();
  endtask

  task automatic wb(input logic [2:0] idx);
    wb_valid = 1'b1;
    wb_dest  = idx;
    cycle();
    wb_valid = 1'b0;
  endtask

  logic [15:0] i1, i2, p;

  initial begin
    Rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_dest   = 3'd0;
    step();
    step();
    settle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_slot", {9'd0, obs_slot()}, 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    Rst_n = 1'b1;

    // 1: single issue, operands from A/B/C, dest marked busy
    in_valid = 1'b1;
    in_instr = mk(4'h1, 3'd2, 3'd5, 3'd3, 3'd1);
    settle();
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_srcs", {55'd0, SrcA, SrcB, SrcC}, {55'd0, 3'd5, 3'd3, 3'd1});
    exp_q.push_back(exp_of(in_instr));
    step();
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_dest  = 3'd2;
    settle();
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_busy", 64'(busy_vec), 64'h04);
    step();
    wb_valid = 1'b0;
    settle();
    chk("t1_busy_clr", 64'(busy_vec), 64'h00);
    chk("t1_bubble", 64'(out_valid), 64'd0);
    step();

    // 2: RAW stall, issue the cycle after writeback and never on it
    in_valid = 1'b1;
    in_instr = mk(4'h2, 3'd3, 3'd1, 3'd2, 3'd0);
    settle();
    chk("t2_first_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(exp_of(in_instr));
    step();
    in_instr = mk(4'h2, 3'd4, 3'd3, 3'd1, 3'd1);
    settle();
    chk("t2_stall", 64'(in_ready), 64'd0);
    chk("t2_busy", 64'(busy_vec), 64'h08);
    step();
    wb_valid = 1'b1;
    wb_dest  = 3'd3;
    settle();
    chk("t2_no_bypass", 64'(in_ready), 64'd0);
    step();
    wb_valid = 1'b0;
    settle();
    chk("t2_busy_after_wb", 64'(busy_vec), 64'h00);
    chk("t2_issue", 64'(in_ready), 64'd1);
    exp_q.push_back(exp_of(in_instr));
    step();
    in_valid = 1'b0;
    settle();
    chk("t2_busy_r4", 64'(busy_vec), 64'h10);
    step();
    wb(3'd4);

    // 3: output back-pressure for 5 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    i1 = mk(4'h3, 3'd1, 3'd2, 3'd3, 3'd4);
    i2 = mk(4'h4, 3'd5, 3'd6, 3'd7, 3'd0);
    in_instr = i1;
    settle();
    chk("t3_accept", 64'(in_ready), 64'd1);
    exp_q.push_back(exp_of(i1));
    step();
    in_instr = i2;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_blocked", 64'(in_ready), 64'd0);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_slot", {9'd0, obs_slot()}, {9'd0, exp_of(i1)});
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("t3_release", 64'(in_ready), 64'd1);
    exp_q.push_back(exp_of(i2));
    step();
    in_valid = 1'b0;
    settle();
    chk("t3_busy", 64'(busy_vec), 64'h22);
    step();
    wb(3'd1);
    wb(3'd5);

    // 4: fill every register, then NOPs never stall and never touch busy
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = mk(4'h1, 3'(k), 3'(k), 3'(k), 3'(k));
      settle();
      chk("t4_fill_ready", 64'(in_ready), 64'd1);
      exp_q.push_back(exp_of(in_instr));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      in_instr = (k % 2 == 0) ? 16'h0000 : 16'h0FFF;
      settle();
      chk("t4_nop_ready", 64'(in_ready), 64'd1);
      chk("t4_nop_busy", 64'(busy_vec), 64'hFF);
      exp_q.push_back(exp_of(in_instr));
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("t4_busy_after", 64'(busy_vec), 64'hFF);
    step();

    // 5: issue to R5 while R5 retires: set wins
    wb(3'd5);
    in_valid = 1'b1;
    in_instr = mk(4'h5, 3'd5, 3'd5, 3'd5, 3'd5);
    wb_valid = 1'b1;
    wb_dest  = 3'd5;
    settle();
    chk("t5_busy_before", 64'(busy_vec), 64'hDF);
    chk("t5_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(exp_of(in_instr));
    step();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    settle();
    chk("t5_set_wins", 64'(busy_vec), 64'hFF);
    step();

    // 6: reset while stalled on busy_vec=8'h24
    wb(3'd0);
    wb(3'd1);
    wb(3'd3);
    wb(3'd4);
    wb(3'd6);
    wb(3'd7);
    settle();
    chk("t6_busy_24", 64'(busy_vec), 64'h24);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);
    step();
    p = mk(4'h6, 3'd7, 3'd2, 3'd0, 3'd1);
    in_valid = 1'b1;
    in_instr = p;
    settle();
    chk("t6_stall", 64'(in_ready), 64'd0);
    step();
    Rst_n = 1'b0;
    settle();
    chk("t6_stall_in_rst", 64'(in_ready), 64'd0);
    step();
    Rst_n = 1'b1;
    settle();
    chk("t6_busy_rst", 64'(busy_vec), 64'h00);
    chk("t6_valid_rst", 64'(out_valid), 64'd0);
    chk("t6_slot_rst", {9'd0, obs_slot()}, 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(exp_of(p));
    step();
    in_valid = 1'b0;
    settle();
    chk("t6_busy_r7", 64'(busy_vec), 64'h80);
    step();
    cycle();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
